// File: rtl/button_control_unit.sv
// ---------------------------------------------------------------------------
// button_control_unit
//
// Front-panel controller. It synchronises and debounces NUM_BTN raw buttons
// and maps each button to a function through a per-mode table chosen by the
// slide switches. It emits one-cycle function pulses, with optional
// hold-to-repeat for functions flagged in REPEAT_MASK.
//
// Ports
//   clk         in   system clock (clk_100)
//   reset       in   asynchronous reset, active low (0 = in reset)
//   btn         in   [NUM_BTN-1:0]  raw asynchronous buttons
//   mode_sel    in   [MODE_W-1:0]   raw asynchronous mode switches
//   func_pulse  out  [NUM_FUNC-1:0] one-cycle press / repeat pulses
//   func_held   out  [NUM_FUNC-1:0] level, a button mapped to f is pressed
//   mode        out  [MODE_W-1:0]   mode currently applied to the map
//   any_held    out  high while any debounced button is pressed
// ---------------------------------------------------------------------------
module button_control_unit #(
   parameter int NUM_BTN  = 4,
   parameter int MODE_W   = 2,
   parameter int NUM_FUNC = 6,
   parameter int FUNC_W   = 3,
   parameter logic [(2**MODE_W)*NUM_BTN*FUNC_W-1:0] BTN_MAP = {
      3'd0, 3'd1, 3'd4, 3'd2,
      3'd7, 3'd7, 3'd7, 3'd7,
      3'd7, 3'd7, 3'd7, 3'd7,
      3'd0, 3'd1, 3'd2, 3'd3
   },
   parameter logic [NUM_FUNC-1:0] REPEAT_MASK = 6'b010100,
   parameter int DB_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTN-1:0]  btn,
   input  logic [MODE_W-1:0]   mode_sel,
   output logic [NUM_FUNC-1:0] func_pulse,
   output logic [NUM_FUNC-1:0] func_held,
   output logic [MODE_W-1:0]   mode,
   output logic                any_held
);

   localparam int DB_W    = $clog2(DB_CYCLES + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [NUM_BTN-1:0]  r_btnSync1;
   logic [NUM_BTN-1:0]  r_btnSync2;
   logic [NUM_BTN-1:0]  r_stable;
   logic [NUM_BTN-1:0]  r_stableDly;
   logic [NUM_BTN-1:0]  r_repActive;
   logic [NUM_BTN-1:0]  r_repFirst;
   logic [DB_W-1:0]     r_dbCnt  [NUM_BTN];
   logic [REP_W-1:0]    r_repCnt [NUM_BTN];
   logic [MODE_W-1:0]   r_modeSync1;
   logic [MODE_W-1:0]   r_modeSync2;
   logic [MODE_W-1:0]   r_mode;
   logic [NUM_FUNC-1:0] r_funcPulse;
   logic [NUM_FUNC-1:0] r_funcHeld;
   logic                r_anyHeld;

   logic [FUNC_W-1:0]   w_func [NUM_BTN];
   logic [NUM_BTN-1:0]  w_mapped;
   logic [NUM_BTN-1:0]  w_stableNext;
   logic [NUM_BTN-1:0]  w_rise;
   logic [NUM_BTN-1:0]  w_repHit;
   logic [NUM_BTN-1:0]  w_repFire;
   logic [NUM_FUNC-1:0] w_pulseNext;
   logic [NUM_FUNC-1:0] w_heldNext;

   // Per-button view of the current state. The map field is looked up with
   // the applied mode, which cannot change while a button is held, so a
   // held button keeps its function. w_stableNext is the debounced level
   // after this edge. The repeat logic uses it so that no repeat pulse is
   // issued on the edge where the button is being released. A rise of the
   // debounced level against its delayed copy is the press event.
   always_comb begin
      for (int b = 0; b < NUM_BTN; b++) begin
         w_func[b]       = BTN_MAP[(int'(r_mode) * NUM_BTN + b) * FUNC_W +: FUNC_W];
         w_mapped[b]     = int'(w_func[b]) < NUM_FUNC;
         w_stableNext[b] = ((r_btnSync2[b] != r_stable[b]) && (r_dbCnt[b] == DB_W'(DB_CYCLES)))
                           ? r_btnSync2[b] : r_stable[b];
         w_rise[b]       = r_stable[b] & ~r_stableDly[b];
         w_repHit[b]     = r_repFirst[b] ? (r_repCnt[b] == REP_W'(REPEAT_DELAY))
                                         : (r_repCnt[b] == REP_W'(REPEAT_PERIOD));
         w_repFire[b]    = r_repActive[b] & r_stable[b] & w_stableNext[b] & w_repHit[b];
      end
   end

   // Fold the per-button events onto the function outputs. Several buttons
   // hitting the same function in the same cycle collapse into one pulse,
   // and unmapped buttons contribute nothing at all. Repeat events only
   // count for functions that have auto-repeat enabled.
   always_comb begin
      w_pulseNext = '0;
      w_heldNext  = '0;
      for (int b = 0; b < NUM_BTN; b++) begin
         if (w_mapped[b]) begin
            if (w_rise[b] || (w_repFire[b] && REPEAT_MASK[w_func[b]])) begin
               w_pulseNext[w_func[b]] = 1'b1;
            end
            if (r_stable[b]) begin
               w_heldNext[w_func[b]] = 1'b1;
            end
         end
      end
   end

   // All state lives here. Buttons and switches go through two flops before
   // use. The debounce counter counts consecutive disagreeing samples. Once
   // it already holds DB_CYCLES and the sample still disagrees, the new
   // level is accepted and the counter restarts. The repeat counter starts
   // at 1 on the press edge, so it equals the target exactly on the edge
   // that must launch a repeat pulse. It then reloads to 1 and counts
   // towards the period. A new mode is only taken when no button is
   // debounced-pressed and any_held is low. Checking the debounced bits as
   // well stops a mode switch from slipping in during the single cycle
   // between a press being accepted and any_held rising.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_btnSync1  <= '0;
         r_btnSync2  <= '0;
         r_stable    <= '0;
         r_stableDly <= '0;
         r_repActive <= '0;
         r_repFirst  <= '0;
         r_modeSync1 <= '0;
         r_modeSync2 <= '0;
         r_mode      <= '0;
         r_funcPulse <= '0;
         r_funcHeld  <= '0;
         r_anyHeld   <= 1'b0;
         for (int b = 0; b < NUM_BTN; b++) begin
            r_dbCnt[b]  <= '0;
            r_repCnt[b] <= '0;
         end
      end else begin
         r_btnSync1  <= btn;
         r_btnSync2  <= r_btnSync1;
         r_modeSync1 <= mode_sel;
         r_modeSync2 <= r_modeSync1;
         r_stableDly <= r_stable;

         for (int b = 0; b < NUM_BTN; b++) begin
            if (r_btnSync2[b] == r_stable[b]) begin
               r_dbCnt[b] <= '0;
            end else if (r_dbCnt[b] == DB_W'(DB_CYCLES)) begin
               r_stable[b] <= r_btnSync2[b];
               r_dbCnt[b]  <= '0;
            end else begin
               r_dbCnt[b] <= r_dbCnt[b] + 1'b1;
            end

            if (!w_stableNext[b]) begin
               r_repActive[b] <= 1'b0;
               r_repFirst[b]  <= 1'b0;
               r_repCnt[b]    <= '0;
            end else if (w_rise[b]) begin
               r_repActive[b] <= 1'b1;
               r_repFirst[b]  <= 1'b1;
               r_repCnt[b]    <= REP_W'(1);
            end else if (r_repActive[b]) begin
               if (w_repHit[b]) begin
                  r_repFirst[b] <= 1'b0;
                  r_repCnt[b]   <= REP_W'(1);
               end else begin
                  r_repCnt[b] <= r_repCnt[b] + 1'b1;
               end
            end
         end

         r_funcPulse <= w_pulseNext;
         r_funcHeld  <= w_heldNext;
         r_anyHeld   <= |r_stable;

         if (!r_anyHeld && (r_stable == '0)) begin
            r_mode <= r_modeSync2;
         end
      end
   end

   assign func_pulse = r_funcPulse;
   assign func_held  = r_funcHeld;
   assign mode       = r_mode;
   assign any_held   = r_anyHeld;

endmodule
